// File: rtl/mem_access_stage.sv
// Memory stage: drives a multi-cycle req/ack data-memory access and aligns load data.
// Optional MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into a flagged no-op.
module mem_access_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_mem_valid,
  input  logic                   ex_mem_MemRead,
  input  logic                   ex_mem_MemWrite,
  input  logic                   ex_mem_RegWrite,
  input  logic                   ex_mem_MemtoReg,
  input  logic [1:0]             ex_mem_size,
  input  logic                   ex_mem_unsigned,
  input  logic [31:0]            ex_mem_alu_result,
  input  logic [31:0]            ex_mem_writedata,
  input  logic [4:0]             ex_mem_rd,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic                   dmem_ack,
  input  logic [31:0]            dmem_rdata,
  output logic [31:0]            readdata,
  output logic [31:0]            alu_result,
  output logic [4:0]             mem_rd,
  output logic                   mem_RegWrite,
  output logic                   mem_MemtoReg,
  output logic                   mem_stall,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [31:0] addr;
  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        mis_q;
  logic        start;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic [31:0] cap_data;

  assign addr    = ex_mem_alu_result;
  assign is_byte = ex_mem_size == 2'b00;
  assign is_half = ex_mem_size == 2'b01;
  assign mem_op  = ex_mem_valid &
                   (ex_mem_MemRead | ex_mem_MemWrite);
  assign start   = (state == IDLE) & mem_op;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half & addr[0]) |
                      (~is_byte & ~is_half &
                       (addr[1:0] != 2'b00));
  assign misalign_err = (state == DONE) & mis_q;
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign alu_result   = ex_mem_alu_result;
  assign mem_rd       = ex_mem_rd;
  assign mem_MemtoReg = ex_mem_MemtoReg;

  always_comb begin
    st_wdata = ex_mem_writedata;
    st_be    = 4'b1111;
    unique case (1'b1)
      is_byte: begin
        st_wdata = {4{ex_mem_writedata[7:0]}};
        st_be    = 4'b0001 << addr[1:0];
      end
      is_half: begin
        st_wdata = {2{ex_mem_writedata[15:0]}};
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // EX/MEM is frozen while stalled, so its size/offset are still valid at ack
  always_comb begin
    ld_b    = 8'(dmem_rdata >> {addr[1:0], 3'b000});
    ld_h    = 16'(dmem_rdata >> {addr[1], 4'b0000});
    ld_data = dmem_rdata;
    unique case (1'b1)
      is_byte: ld_data = {{24{~ex_mem_unsigned & ld_b[7]}}, ld_b};
      is_half: ld_data = {{16{~ex_mem_unsigned & ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    mem_stall    = 1'b0;
    mem_RegWrite = ex_mem_valid & ex_mem_RegWrite;
    readdata     = '0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall    = 1'b1;
          mem_RegWrite = 1'b0;
          state_nx     = misaligned ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        mem_stall    = 1'b1;
        mem_RegWrite = 1'b0;
        if (dmem_ack) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        if (mis_q)               mem_RegWrite = 1'b0;
        else if (ex_mem_MemRead) readdata     = cap_data;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_be      <= '0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      cap_data     <= '0;
      mis_q        <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (start) begin
        mis_q <= misaligned;
        if (!misaligned) begin
          dmem_req   <= 1'b1;
          dmem_we    <= ex_mem_MemWrite;
          dmem_addr  <= {addr[31:2], 2'b00};
          dmem_wdata <= st_wdata;
          dmem_be    <= ex_mem_MemWrite ? st_be : 4'b1111;
        end
      end
      if (state == ACCESS && dmem_ack) begin
        dmem_req <= 1'b0;
        cap_data <= ld_data;
      end
      if (mem_stall && !(&stall_cycles))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule
